fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one `fifo` instance's write port among NREQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST beats.
- It drives the FIFO's `wr`/`dataIn`/`en` and honours its `full` flag.
- It sits between the producer blocks and the `fifo` write side; the read side is untouched.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DWIDTH, 8, data width; must match the FIFO DWIDTH.
- BURST, 4, maximum accepted beats per grant (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester data valid.
- req_data  input  NREQ*DWIDTH  packed data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_ready  output  NREQ  per-requester accept; a beat transfers when valid && ready.
- fifo_full  input  1  FIFO `full` flag.
- fifo_wr  output  1  to FIFO `wr`.
- fifo_en  output  1  to FIFO `en`.
- fifo_data  output  DWIDTH  to FIFO `dataIn`.
- grant  output  NREQ  one-hot current owner; all-zero when idle.
- busy  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high on `rst`. Ports are named `clk` and `rst`, matching the codebase.

Reset values:
- state=IDLE, grant=0, busy=0, beat count=0.
- Round-robin pointer = NREQ-1, so requester 0 has top priority first.
- fifo_en=0.
- The combinational outputs req_ready, fifo_wr and fifo_data are 0 because grant=0.

fifo_en:
- A register that goes to 1 on the first clk edge after rst deasserts, then stays 1.

State IDLE:
- req_ready=0, fifo_wr=0.
- If any req_valid is high, select the first set bit searching upward from pointer+1 (mod NREQ).
- At the next edge: grant <= onehot(sel), count <= 0, state <= GRANT.
- One-cycle arbitration latency; no write occurs in the IDLE cycle.

State GRANT (owner g):
- req_ready[g] = !fifo_full. All other req_ready bits are 0.
- fifo_data = req_data slice g. This is combinational.
- fifo_wr = req_valid[g] && !fifo_full.
- Accepted beat = fifo_wr; count increments on each accepted beat.
- fifo_full=1 stalls: no write, count and grant are held, no timeout.
- A requester must hold its data stable while valid && !ready.

Release conditions (evaluated each GRANT cycle):
- (a) accepted beat with count==BURST-1, or
- (b) req_valid[g]==0; no beat occurs in that cycle.

On release:
- pointer <= g.
- Re-arbitrate on the current-cycle req_valid, searching from g+1. Under (a), g has lowest priority but may win if it is the only requester. Under (b), g is excluded because its valid is low.
- If a winner exists: stay in GRANT, load the new grant, count <= 0. There is no bubble between bursts.
- Otherwise: go to IDLE with grant <= 0.

Boundary conditions:
- BURST=1: each accepted beat releases the grant.
- fifo_full and release condition (b) in the same cycle: release proceeds, since there is no beat to lose.
- rst asserted mid-burst: immediately (asynchronously) returns to the reset values. A beat presented in that cycle is not written, because fifo_wr is forced to 0 and fifo_en to 0.
- Requester count is assumed constant; only the grant owner is ever ready.

Test Plan:
Common setup: NREQ=2, DWIDTH=8, BURST=4, FIFO DWIDTH=8, AWIDTH=3, 20 ns clock.
1. Reset: hold rst=1 for 2 cycles -> grant=00, busy=0, fifo_wr=0, req_ready=00, fifo_en=0. Release rst -> fifo_en=1 after the next edge.
2. Single producer: req0 streams 0x10..0x15 continuously -> grant=01 the cycle after valid. Six consecutive fifo_wr cycles write 0x10..0x15 with a direct self-regrant after 0x13 and no gap. req0 drops valid -> grant=00 and IDLE after the next edge.
3. Contention: req0 streams 0xA0+ and req1 streams 0xB0+, both continuously valid from reset -> FIFO receives A0 A1 A2 A3 B0 B1 B2 B3 A4 ... with no idle cycles between bursts.
4. Backpressure: during the req0 burst, fifo_full=1 for 3 cycles after 2 beats -> fifo_wr=0, req_ready=00, grant held at 01. After full clears, exactly 2 more beats are written, then grant switches to 10.
5. Early release: req1 owns the grant and drops valid after 2 beats while req0 is valid -> grant=01 on the next edge, and the first req0 beat is written that cycle.
6. Reset mid-burst: assert rst asynchronously during beat 2 of a req1 grant -> all outputs 0 immediately, and the FIFO does not capture that beat. After release with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ valid/ready producers.
// Each grant lasts up to BURST accepted beats. After a release the next owner is granted in the same cycle.
module fifo_wr_arbiter #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic                   fifo_en,
  output logic [DWIDTH-1:0]      fifo_data,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   owner, owner_n;
  logic [CW-1:0]   count, count_n;
  logic [NREQ-1:0] grant_n;
  logic [IW:0]     pick;
  logic            release_now;

  // Returns {found, index}: the first valid requester searching upward from last+1, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IW-1:0] last);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign busy = (state == GRANT);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_data = '0;
    if (state == GRANT) begin
      req_ready[owner] = !fifo_full;
      fifo_wr          = req_valid[owner] && !fifo_full;
      fifo_data        = req_data[owner*DWIDTH +: DWIDTH];
    end
  end

  // Release after the last beat of a burst, or as soon as the owner drops valid.
  assign release_now = (fifo_wr && (count == CW'(BURST - 1))) || !req_valid[owner];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    count_n = count;
    grant_n = grant;
    pick    = '0;
    unique case (state)
      IDLE: begin
        pick = rr_pick(req_valid, ptr);
        if (pick[IW]) begin
          state_n = GRANT;
          owner_n = pick[IW-1:0];
          grant_n = {{(NREQ-1){1'b0}}, 1'b1} << pick[IW-1:0];
          count_n = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n   = owner;
          count_n = '0;
          pick    = rr_pick(req_valid, owner);
          if (pick[IW]) begin
            owner_n = pick[IW-1:0];
            grant_n = {{(NREQ-1){1'b0}}, 1'b1} << pick[IW-1:0];
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else if (fifo_wr) begin
          count_n = count + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      owner <= '0;
      count <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      count <= count_n;
      grant <= grant_n;
    end
  end

  // FIFO enable rises on the first edge after reset and then stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fifo_en <= 1'b0;
    else     fifo_en <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected FIFO writes are queued as stimulus is loaded
// and popped whenever the DUT asserts fifo_wr.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 2;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr;
  logic              fifo_en;
  logic [DW-1:0]     fifo_data;
  logic [NREQ-1:0]   grant;
  logic              busy;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] exp_q[$];
  logic [1:0] en = 2'b00;
  logic [1:0] fire;
  logic [7:0] exp_v;
  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_en(fifo_en), .fifo_data(fifo_data),
    .grant(grant), .busy(busy)
  );

  initial forever #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    req_valid[0]  = en[0] && (src0.size() > 0);
    req_valid[1]  = en[1] && (src1.size() > 0);
    req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
    req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
  endtask

  // Producers and FIFO-side monitor: sample at negedge, advance sources just after posedge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    fire      = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      if (fifo_wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fifo_write: unexpected write got %h want none", fifo_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (fifo_data !== exp_v) begin
            errors++;
            $display("FAIL fifo_write: got %h want %h", fifo_data, exp_v);
          end
        end
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        if (fire[0] && src0.size() > 0) void'(src0.pop_front());
        if (fire[1] && src1.size() > 0) void'(src1.pop_front());
      end
      #1;
      drive();
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && !(exp_q.size() == 0 && grant == 2'b00); i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL %s_drain: got pending=%0d grant=%b want pending=0 grant=00", name, exp_q.size(), grant);
    end
    @(posedge clk);
    #1;
    en = 2'b00;
    src0.delete();
    src1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 2'b00)     begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_wr !== 1'b0)    begin errors++; $display("FAIL reset_wr: got %b want 0", fifo_wr); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (fifo_en !== 1'b0)    begin errors++; $display("FAIL reset_en: got %b want 0", fifo_en); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", fifo_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL en_before_edge: got %b want 0", fifo_en); end
    @(negedge clk);
    checks++; if (fifo_en !== 1'b1) begin errors++; $display("FAIL en_after_edge: got %b want 1", fifo_en); end
  endtask

  task automatic test_single();
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      src0.push_back(8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
    end
    en = 2'b01;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || fifo_wr !== 1'b0) begin errors++; $display("FAIL single_arb: got grant=%b wr=%b want 00/0", grant, fifo_wr); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || fifo_wr !== 1'b1) begin errors++; $display("FAIL single_beat%0d: got grant=%b wr=%b want 01/1", i, grant, fifo_wr); end
    end
    @(negedge clk);
    checks++; if (grant !== 2'b01 || fifo_wr !== 1'b0) begin errors++; $display("FAIL single_drop: got grant=%b wr=%b want 01/0", grant, fifo_wr); end
    @(negedge clk);
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got grant=%b busy=%b want 00/0", grant, busy); end
    wait_drain("single");
  endtask

  task automatic test_contention();
    logic [1:0] want;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src0.push_back(8'(8'hA0 + i));
      src1.push_back(8'(8'hB0 + i));
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA0 + 4*b + i));
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hB0 + 4*b + i));
    end
    en = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || fifo_wr !== 1'b0) begin errors++; $display("FAIL contention_arb: got grant=%b wr=%b want 00/0", grant, fifo_wr); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      want = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      checks++;
      if (grant !== want || fifo_wr !== 1'b1) begin errors++; $display("FAIL contention_beat%0d: got grant=%b wr=%b want %b/1", i, grant, fifo_wr, want); end
    end
    wait_drain("contention");
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 6; i++) src0.push_back(8'(8'hC0 + i));
    src1.push_back(8'hD0);
    src1.push_back(8'hD1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hC0 + i));
    exp_q.push_back(8'hD0);
    exp_q.push_back(8'hD1);
    exp_q.push_back(8'hC4);
    exp_q.push_back(8'hC5);
    en = 2'b11;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b0 || req_ready !== 2'b00 || grant !== 2'b01) begin
        errors++; $display("FAIL full_stall%0d: got wr=%b ready=%b grant=%b want 0/00/01", i, fifo_wr, req_ready, grant);
      end
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL full_resume%0d: got wr=%b grant=%b want 1/01", i, fifo_wr, grant); end
    end
    @(negedge clk);
    checks++; if (grant !== 2'b10 || fifo_wr !== 1'b1) begin errors++; $display("FAIL full_switch: got grant=%b wr=%b want 10/1", grant, fifo_wr); end
    wait_drain("backpressure");
  endtask

  task automatic test_early_release();
    apply_reset();
    src1.push_back(8'hE0);
    src1.push_back(8'hE1);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hF1);
    en = 2'b10;
    @(negedge clk);
    @(posedge clk);
    #1;
    src0.push_back(8'hF0);
    src0.push_back(8'hF1);
    en = 2'b11;
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL early_owner: got %b want 10", grant); end
    @(negedge clk);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b10 || fifo_wr !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL early_drop: got grant=%b wr=%b ready=%b want 10/0/00", grant, fifo_wr, req_ready); end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || fifo_wr !== 1'b1) begin errors++; $display("FAIL early_handover: got grant=%b wr=%b want 01/1", grant, fifo_wr); end
    wait_drain("early");
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 4; i++) src1.push_back(8'(8'h60 + i));
    exp_q.push_back(8'h60);
    en = 2'b10;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || fifo_wr !== 1'b0 || req_ready !== 2'b00 || fifo_en !== 1'b0 || fifo_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: got grant=%b busy=%b wr=%b ready=%b en=%b data=%h want all zero",
               grant, busy, fifo_wr, req_ready, fifo_en, fifo_data);
    end
    src0.push_back(8'h70);
    src0.push_back(8'h71);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    for (int i = 1; i < 4; i++) exp_q.push_back(8'(8'h60 + i));
    en = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL midrst_regrant: got %b want 01", grant); end
    wait_drain("midrst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
